// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, default frame width and
// the FIFO sizing reused by both the transmit and receive buffers.
package uart_pkg;

    localparam int UART_DBIT        = 8;
    localparam int UART_FIFO_ADDR_W = 4;
    localparam int UART_FIFO_DEPTH  = 1 << UART_FIFO_ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Occupancy is tracked by an explicit counter so that
// full and empty never depend on pointer equality.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DW = UART_DBIT,
    parameter int AW = UART_FIFO_ADDR_W
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam int          DEPTH      = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    // A push at full is refused even when a pop happens in the same cycle.
    assign push_ok = i_push && (count_reg != FULL_COUNT);
    assign pop_ok  = i_pop && (count_reg != '0);

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign o_rdata = mem[rd_ptr_reg];
    assign o_full  = (count_reg == FULL_COUNT);
    assign o_empty = (count_reg == '0);
    assign o_count = count_reg;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit buffer and sequencer feeding the UART transmitter one byte per frame.
// Define UART_TX_FIFO_OVF_EN to add the sticky o_overflow flag and its i_ovf_clr input.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [DBIT-1:0]   i_wdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    input  logic              i_tx_done_tick,
    output logic              o_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic              o_overflow,
    input  logic              i_ovf_clr
`endif
);

    tx_state_t       state_reg;
    logic            start_reg;
    logic [DBIT-1:0] data_reg;
    logic [DBIT-1:0] head_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    // The pop coincides with the edge that latches the head byte and leaves IDLE.
    assign pop = (state_reg == IDLE) && !fifo_empty;

    sync_fifo #(
        .DW (DBIT),
        .AW (ADDR_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_wr),
        .i_wdata (i_wdata),
        .i_pop   (pop),
        .o_rdata (head_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= IDLE;
            start_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        data_reg  <= head_data;
                        start_reg <= 1'b1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_tx_done_tick) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_full     = fifo_full;
    assign o_empty    = fifo_empty;
    assign o_tx_start = start_reg;
    assign o_tx_data  = data_reg;
    assign o_busy     = (state_reg == WAIT);

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_reg;

    // A new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovf_reg <= 1'b0;
        end else if (i_wr && fifo_full) begin
            ovf_reg <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign o_overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl against a queue-based cycle model.
module tb_uart_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, wr, done, clr;
    logic [7:0] wdata;
    logic       full, empty, start, busy;
    logic [4:0] count;
    logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo_ctrl dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_wr           (wr),
        .i_wdata        (wdata),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count),
        .o_tx_start     (start),
        .o_tx_data      (tx_data),
        .i_tx_done_tick (done),
        .o_busy         (busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .o_overflow     (ovf),
        .i_ovf_clr      (clr)
`endif
    );

    // Reference model: queued bytes, frame-in-flight flag, last byte handed out.
    logic [7:0] m_q[$];
    bit         m_busy, m_start, m_ovf;
    logic [7:0] m_data;

    int n_assert = 0;
    int n_fail   = 0;
    int n_starts = 0;
    bit saw_ff   = 0;
    bit auto_tx  = 0;
    int tx_timer = -1;
    int tx_delay = 30;
    bit rand_delay = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input bit w, input logic [7:0] d, input bit dn, input bit r, input bit c);
        bit auto_done;
        bit pop, acc;
        auto_done = 1'b0;
        if (auto_tx && tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) begin
                auto_done = 1'b1;
                tx_timer  = -1;
            end
        end
        wr = w; wdata = d; done = dn | auto_done; rst = r; clr = c;
        @(posedge clk);
        #1;
        if (r) begin
            m_q.delete();
            m_busy = 0; m_start = 0; m_data = 8'h00; m_ovf = 0;
            tx_timer = -1;
        end else begin
            pop = !m_busy && (m_q.size() > 0);
            acc = w && (m_q.size() < 16);
            if (w && m_q.size() == 16) m_ovf = 1;
            else if (c) m_ovf = 0;
            m_start = pop;
            if (pop) begin
                m_data = m_q.pop_front();
                m_busy = 1;
            end else if (m_busy && done) begin
                m_busy = 0;
            end
            if (acc) m_q.push_back(d);
        end
        if (m_start && auto_tx) begin
            if (rand_delay) tx_delay = $urandom_range(1, 4);
            tx_timer = tx_delay;
        end
        if (start === 1'b1) begin
            n_starts++;
            if (tx_data === 8'hFF) saw_ff = 1;
        end
        chk("count",   32'(count),   32'(m_q.size()));
        chk("empty",   32'(empty),   32'(m_q.size() == 0));
        chk("full",    32'(full),    32'(m_q.size() == 16));
        chk("start",   32'(start),   32'(m_start));
        chk("busy",    32'(busy),    32'(m_busy));
        chk("tx_data", 32'(tx_data), 32'(m_data));
`ifdef UART_TX_FIFO_OVF_EN
        chk("overflow", 32'(ovf), 32'(m_ovf));
`endif
        $display("t=%0t wr=%0b wd=%02h done=%0b rst=%0b | cnt=%0d start=%0b data=%02h busy=%0b",
                 $time, w, d, done, r, count, start, tx_data, busy);
    endtask

    initial begin
        wr = 0; wdata = 8'h00; done = 0; rst = 1; clr = 0;

        // Reset then idle
        tick(0, 8'h00, 0, 1, 0);
        tick(0, 8'h00, 0, 1, 0);
        repeat (20) tick(0, 8'h00, 0, 0, 0);
        chk("idle_no_start", 32'(n_starts), 32'd0);

        // Single byte with a manually timed done tick
        n_starts = 0;
        tick(1, 8'hA5, 0, 0, 0);
        repeat (33) tick(0, 8'h00, 0, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        repeat (10) tick(0, 8'h00, 0, 0, 0);
        chk("single_starts", 32'(n_starts), 32'd1);

        // Burst of five with a 30-cycle transmitter
        n_starts = 0;
        auto_tx = 1; tx_delay = 30;
        for (int i = 1; i <= 5; i++) tick(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 250 && (m_busy || m_q.size() > 0); i++) tick(0, 8'h00, 0, 0, 0);
        repeat (5) tick(0, 8'h00, 0, 0, 0);
        chk("burst_starts", 32'(n_starts), 32'd5);
        chk("burst_drained", 32'(m_busy || m_q.size() > 0), 32'd0);

        // Fill with done withheld, then overflow
        auto_tx = 0; saw_ff = 0;
        for (int i = 0; i < 17; i++) tick(1, 8'($urandom_range(0, 254)), 0, 0, 0);
        chk("fill_count", 32'(count), 32'd16);
        tick(1, 8'hFF, 0, 0, 0);
        repeat (3) tick(0, 8'h00, 0, 0, 0);
        tick(1, 8'hFF, 0, 0, 1);
        repeat (2) tick(0, 8'h00, 0, 0, 0);
        tick(0, 8'h00, 0, 0, 1);
        repeat (2) tick(0, 8'h00, 0, 0, 0);
        auto_tx = 1; tx_delay = 3;
        tick(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 200 && (m_busy || m_q.size() > 0); i++) tick(0, 8'h00, 0, 0, 0);
        repeat (3) tick(0, 8'h00, 0, 0, 0);
        chk("no_ff_emitted", 32'(saw_ff), 32'd0);
        chk("fill_drained", 32'(m_busy || m_q.size() > 0), 32'd0);

        // Random push/pop traffic to wrap the pointers
        rand_delay = 1;
        for (int i = 0; i < 150; i++) tick(1'($urandom_range(0, 1)), 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 150 && (m_busy || m_q.size() > 0); i++) tick(0, 8'h00, 0, 0, 0);
        repeat (3) tick(0, 8'h00, 0, 0, 0);
        chk("rand_drained", 32'(m_busy || m_q.size() > 0), 32'd0);
        rand_delay = 0;

        // Reset during a frame with four bytes queued
        auto_tx = 0;
        for (int i = 0; i < 5; i++) tick(1, 8'(8'h30 + i), 0, 0, 0);
        repeat (3) tick(0, 8'h00, 0, 0, 0);
        chk("pre_reset_count", 32'(count), 32'd4);
        tick(0, 8'h00, 0, 1, 0);
        n_starts = 0;
        tick(0, 8'h00, 1, 0, 0);
        repeat (10) tick(0, 8'h00, 0, 0, 0);
        chk("post_reset_starts", 32'(n_starts), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
